ccsds_randomizer: RTL and testbench
===================================

CCSDS_RANDOMIZER -- requirements
Module: ccsds_randomizer

Interface
REQ-001 SHALL have parameter FRAME_WORDS, default 65, meaning 32-bit words per frame: 1 ASM word plus 64 codeblock words.
REQ-002 SHALL have parameter PAD_BYTES, default 1, meaning trailing bytes of the last frame word passed unrandomized; legal range 0..3.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port core_clk  input  1  clock; all logic in this single domain.
REQ-005 SHALL have port s_axis_tdata  input  32  framed word stream; the first byte of each word is in [31:24].
REQ-006 SHALL have ports s_axis_tvalid/s_axis_tlast  input  1 each, and s_axis_tready  output  1: the AXI-Stream slave handshake.
REQ-007 SHALL have port m_axis_tdata  output  32  randomized word stream, same byte order as the input.
REQ-008 SHALL have ports m_axis_tvalid/m_axis_tlast  output  1 each, and m_axis_tready  input  1: the AXI-Stream master handshake.
REQ-009 SHALL have port frame_err_o  output  1  frame-length error pulse; the port exists only with RAND_FRAME_CHK_EN.

Function
REQ-010 A word transfers when tvalid and tready are both high in the same cycle; tdata/tlast are held stable while tvalid is high and tready is low.
REQ-011 A word counter wcnt (7 bit) SHALL count accepted input words from 0 and mark position 0 as the ASM word.
REQ-012 wcnt SHALL return to 0 after an accepted word with s_axis_tlast=1, or after the accepted word at wcnt=FRAME_WORDS-1, whichever occurs first.
REQ-013 The ASM word (wcnt=0) SHALL pass unmodified.
REQ-014 Codeblock words SHALL be XORed with the CCSDS pseudo-random sequence: h(x)=x^8+x^7+x^5+x^3+1, 8-bit LFSR, first sequence bit at tdata[31].
REQ-015 The LFSR SHALL be seeded to 8'hFF on each accepted ASM word and advanced exactly 32 bits per accepted codeblock word, combinationally unrolled in one cycle.
REQ-016 The mask for the first codeblock word SHALL be 32'hFF480EC0 and for the second 32'h9A0D70BC.
REQ-017 In the word at wcnt=FRAME_WORDS-1, the lowest PAD_BYTES bytes SHALL pass unmodified; the LFSR still advances 32 bits.
REQ-018 m_axis_tlast SHALL equal the s_axis_tlast of the corresponding input word and SHALL NOT be regenerated from the counter.
REQ-019 The datapath SHALL be an output register plus a one-entry skid buffer, with input-to-output latency of 1 cycle when m_axis_tready=1.
REQ-020 Sustained throughput SHALL be 1 word/cycle.
REQ-021 s_axis_tready SHALL be registered and SHALL equal NOT(skid full).
REQ-022 The skid buffer SHALL fill only when the output register holds valid data and m_axis_tready=0 in a cycle where an input word is accepted.
REQ-023 Whenever m_axis_tready returns high, the output SHALL drain in order: the output register first, then the skid entry; no word SHALL be lost or duplicated.
REQ-024 Simultaneous input accept and output drain SHALL keep occupancy unchanged.
REQ-025 Masking SHALL be applied before the output/skid registers, so stored words are already randomized.

Reset
REQ-026 On rst the block SHALL set m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata=0, s_axis_tready=0, wcnt=0, LFSR=8'hFF, skid empty and frame_err_o=0.
REQ-027 s_axis_tready SHALL rise on the first core_clk edge after rst deasserts.
REQ-028 Asserting rst mid-frame SHALL discard all buffered words; the next accepted word SHALL be treated as an ASM word.

Configuration
REQ-029 The macro RAND_FRAME_CHK_EN SHALL control the frame-length check.
REQ-030 With RAND_FRAME_CHK_EN defined, frame_err_o SHALL pulse high for 1 cycle, registered, the cycle after accepting either a tlast word with wcnt!=FRAME_WORDS-1 or the word at wcnt=FRAME_WORDS-1 without tlast.
REQ-031 Without RAND_FRAME_CHK_EN, the frame_err_o port and its logic SHALL be absent and data behaviour SHALL be identical.

Verification
REQ-032 The bench SHALL send a 65-word frame, ASM 32'h1ACFFC1D then all-zero payload, and check output word0 = 32'h1ACFFC1D, word1 = 32'hFF480EC0, word2 = 32'h9A0D70BC, and tlast only on word64.
REQ-033 The bench SHALL send two back-to-back frames and check that frame-2 word1 again equals 32'hFF480EC0 (reseed) and that zero-idle streaming gives 130 outputs in 131 cycles.
REQ-034 The bench SHALL use all-zero frame input with PAD_BYTES=1 and check that output word64[7:0] = 8'h00.
REQ-035 The bench SHALL apply random m_axis_tready (50%) with continuous input for 10 frames and check that the output equals a reference model bit-exactly, that s_axis_tready falls only with 2 words held, and that there is no loss or duplication.
REQ-036 The bench SHALL send tlast on word 10 with RAND_FRAME_CHK_EN and check for one frame_err_o pulse, and that the following word passes unmodified as ASM.
REQ-037 The bench SHALL assert rst at word 30 with 2 words buffered and check for m_axis_tvalid=0 within the same cycle, and that the next frame restarts with mask 32'hFF480EC0 on word1.

Source files
------------

// File: rtl/ccsds_randomizer.sv
// ccsds_randomizer: CCSDS pseudo-randomizer on a 32-bit AXI-Stream of ASM-framed words.
// Defining RAND_FRAME_CHK_EN adds the frame_err_o frame-length check.
module ccsds_randomizer #(
  parameter int FRAME_WORDS = 65,
  parameter int PAD_BYTES   = 1
) (
  input  logic        rst,
  input  logic        core_clk,
  input  logic [31:0] s_axis_tdata,
  input  logic        s_axis_tvalid,
  input  logic        s_axis_tlast,
  output logic        s_axis_tready,
  output logic [31:0] m_axis_tdata,
  output logic        m_axis_tvalid,
  output logic        m_axis_tlast,
  input  logic        m_axis_tready
`ifdef RAND_FRAME_CHK_EN
  ,
  output logic        frame_err_o
`endif
);
  localparam logic [6:0]  LAST_W    = 7'(FRAME_WORDS - 1);
  localparam logic [31:0] KEEP_MASK = ~((32'd1 << (8 * PAD_BYTES)) - 32'd1);

  logic [6:0]  wcnt_q, wcnt_d;
  logic [7:0]  lfsr_q, lfsr_d, lfsr_adv;
  logic [31:0] mask, in_data;
  logic        accept, is_asm, is_last;
  logic        out_valid_q, out_valid_d, out_last_q, out_last_d;
  logic [31:0] out_data_q, out_data_d;
  logic        skid_valid_q, skid_valid_d, skid_last_q, skid_last_d;
  logic [31:0] skid_data_q, skid_data_d;
  logic        rdy_q, out_free, skid_load;

  // 32 LFSR steps per word; state bit 7 is the oldest sequence bit
  always_comb begin
    lfsr_adv = lfsr_q;
    mask     = '0;
    for (int i = 0; i < 32; i++) begin
      mask[31-i] = lfsr_adv[7];
      lfsr_adv   = {lfsr_adv[6:0], lfsr_adv[7] ^ lfsr_adv[4] ^ lfsr_adv[2] ^ lfsr_adv[0]};
    end
  end

  assign accept  = s_axis_tvalid & rdy_q;
  assign is_asm  = wcnt_q == '0;
  assign is_last = wcnt_q == LAST_W;
  assign in_data = is_asm ? s_axis_tdata : s_axis_tdata ^ (is_last ? mask & KEEP_MASK : mask);
  assign wcnt_d  = !accept ? wcnt_q : (s_axis_tlast || is_last) ? 7'd0 : wcnt_q + 7'd1;
  assign lfsr_d  = !accept ? lfsr_q : is_asm ? 8'hFF : lfsr_adv;

  // Output register refills from the skid entry first so order is preserved
  assign out_free     = !out_valid_q || m_axis_tready;
  assign skid_load    = !out_free && accept;
  assign out_valid_d  = out_free ? (skid_valid_q || accept) : out_valid_q;
  assign out_data_d   = !out_free ? out_data_q : skid_valid_q ? skid_data_q : in_data;
  assign out_last_d   = !out_free ? out_last_q : skid_valid_q ? skid_last_q : s_axis_tlast;
  assign skid_valid_d = skid_load || (skid_valid_q && !out_free);
  assign skid_data_d  = skid_load ? in_data : skid_data_q;
  assign skid_last_d  = skid_load ? s_axis_tlast : skid_last_q;

  always_ff @(posedge core_clk or posedge rst) begin
    if (rst) begin
      wcnt_q       <= '0;
      lfsr_q       <= 8'hFF;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_last_q   <= 1'b0;
      skid_valid_q <= 1'b0;
      skid_data_q  <= '0;
      skid_last_q  <= 1'b0;
      rdy_q        <= 1'b0;
    end else begin
      wcnt_q       <= wcnt_d;
      lfsr_q       <= lfsr_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_last_q   <= out_last_d;
      skid_valid_q <= skid_valid_d;
      skid_data_q  <= skid_data_d;
      skid_last_q  <= skid_last_d;
      rdy_q        <= !skid_valid_d;
    end
  end

  assign s_axis_tready = rdy_q;
  assign m_axis_tdata  = out_data_q;
  assign m_axis_tvalid = out_valid_q;
  assign m_axis_tlast  = out_last_q;

`ifdef RAND_FRAME_CHK_EN
  logic err_q;
  always_ff @(posedge core_clk or posedge rst) begin
    if (rst) err_q <= 1'b0;
    else err_q <= accept && (s_axis_tlast != is_last);
  end
  assign frame_err_o = err_q;
`endif
endmodule

// File: tb/tb_ccsds_randomizer.sv
// tb_ccsds_randomizer: directed checks of ccsds_randomizer against hand values and a bit-serial sequence model.
module tb_ccsds_randomizer;
  typedef struct packed {logic l; logic [31:0] d;} word_t;
  logic        rst, core_clk;
  logic [31:0] s_tdata, m_tdata;
  logic        s_tvalid, s_tlast, s_tready, m_tvalid, m_tlast, m_tready;
`ifdef RAND_FRAME_CHK_EN
  logic frame_err;
  int   nerr = 0;
`endif
  int          errors = 0, checks = 0;
  int          midx = 0, occ = 0, settle = 2, b = 0, nl = 0;
  bit          rnd = 0;
  bit          prn [0:2055];
  word_t       exp_q[$];
  word_t       e_w;
  logic [31:0] cap_d[$];
  logic        cap_l[$];
  logic [31:0] w;
  time         t_acc = 0, t_out = 0, t0 = 0;

  ccsds_randomizer dut (
    .rst(rst), .core_clk(core_clk),
    .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tlast(s_tlast), .s_axis_tready(s_tready),
    .m_axis_tdata(m_tdata), .m_axis_tvalid(m_tvalid), .m_axis_tlast(m_tlast), .m_axis_tready(m_tready)
`ifdef RAND_FRAME_CHK_EN
    , .frame_err_o(frame_err)
`endif
  );

  initial core_clk = 1'b0;
  always #5 core_clk = ~core_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model(input logic [31:0] d, input int idx);
    logic [31:0] m;
    m = '0;
    if (idx == 0) return d;
    for (int j = 0; j < 32; j++) m[31-j] = prn[(idx-1)*32 + j];
    if (idx == 64) m[7:0] = 8'h00;
    return d ^ m;
  endfunction

  // Handshakes are sampled mid-cycle; they complete at the following rising edge
  always @(negedge core_clk) begin
    if (rst) begin
      occ = 0;
      settle = 2;
    end else begin
      if (settle > 0) settle--;
      if (settle == 0) chk("tready_vs_held", 32'(s_tready), 32'(occ < 2));
`ifdef RAND_FRAME_CHK_EN
      if (frame_err) nerr++;
`endif
      if (m_tvalid && m_tready) begin
        chk("output_expected", 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) begin
          e_w = exp_q.pop_front();
          chk("sb_data", m_tdata, e_w.d);
          chk("sb_last", 32'(m_tlast), 32'(e_w.l));
        end
        cap_d.push_back(m_tdata);
        cap_l.push_back(m_tlast);
        t_out = $time;
      end
      occ += int'(s_tvalid && s_tready) - int'(m_tvalid && m_tready);
    end
  end

  task automatic send(input logic [31:0] d, input logic l);
    bit acc = 0;
    int n = 0;
    s_tdata = d;
    s_tlast = l;
    s_tvalid = 1'b1;
    while (!acc && n < 200) begin
      if (rnd) m_tready = 1'($urandom_range(0, 1));
      @(negedge core_clk);
      acc = s_tready;
      if (acc) t_acc = $time;
      n++;
      @(posedge core_clk);
      #1;
    end
    chk("input_accepted", 32'(acc), 32'd1);
    if (acc) begin
      exp_q.push_back({l, model(d, midx)});
      midx = (l || midx == 64) ? 0 : midx + 1;
    end
  endtask

  task automatic send_frame(input logic [31:0] asm_w, input int n, input bit rand_data);
    send(asm_w, n == 0);
    for (int i = 1; i <= n; i++) send(rand_data ? $urandom : 32'h0, i == n);
  endtask

  task automatic idle(input int n);
    s_tvalid = 1'b0;
    s_tlast = 1'b0;
    repeat (n) begin
      @(posedge core_clk);
      #1;
    end
  endtask

  initial begin
    for (int i = 0; i < 8; i++) prn[i] = 1'b1;
    for (int i = 0; i < 2048; i++) prn[i+8] = prn[i+7] ^ prn[i+5] ^ prn[i+3] ^ prn[i];
    rst = 1'b1; s_tdata = '0; s_tvalid = 1'b0; s_tlast = 1'b0; m_tready = 1'b1;
    repeat (2) @(posedge core_clk);
    #1;
    chk("rst_m_tvalid", 32'(m_tvalid), 32'd0);
    chk("rst_m_tlast", 32'(m_tlast), 32'd0);
    chk("rst_m_tdata", m_tdata, 32'h0);
    chk("rst_s_tready", 32'(s_tready), 32'd0);
    rst = 1'b0;
    #1 chk("tready_before_edge", 32'(s_tready), 32'd0);
    @(posedge core_clk);
    #1 chk("tready_first_edge", 32'(s_tready), 32'd1);

    b = cap_d.size();
    send_frame(32'h1ACFFC1D, 64, 0);
    idle(4);
    chk("f1_count", 32'(cap_d.size() - b), 32'd65);
    chk("f1_word0", cap_d[b], 32'h1ACFFC1D);
    chk("f1_word1", cap_d[b+1], 32'hFF480EC0);
    chk("f1_word2", cap_d[b+2], 32'h9A0D70BC);
    w = cap_d[b+64];
    chk("f1_word64_pad", 32'(w[7:0]), 32'h00);
    nl = 0;
    for (int i = 0; i < 65; i++) nl += int'(cap_l[b+i]);
    chk("f1_tlast_count", 32'(nl), 32'd1);
    chk("f1_tlast_word64", 32'(cap_l[b+64]), 32'd1);

    b = cap_d.size();
    send(32'h1ACFFC1D, 1'b0);
    t0 = t_acc;
    for (int i = 1; i <= 64; i++) send(32'h0, i == 64);
    send_frame(32'h1ACFFC1D, 64, 0);
    idle(4);
    chk("b2b_count", 32'(cap_d.size() - b), 32'd130);
    chk("b2b_f2_word0", cap_d[b+65], 32'h1ACFFC1D);
    chk("b2b_f2_word1_reseed", cap_d[b+66], 32'hFF480EC0);
    chk("b2b_span_cycles", 32'((t_out - t0) / 10), 32'd130);

    b = cap_d.size();
    rnd = 1'b1;
    for (int f = 0; f < 10; f++) send_frame($urandom, 64, 1);
    rnd = 1'b0;
    m_tready = 1'b1;
    idle(8);
    chk("rand_count", 32'(cap_d.size() - b), 32'd650);
    chk("rand_backlog", 32'(exp_q.size()), 32'd0);

`ifdef RAND_FRAME_CHK_EN
    chk("err_none_yet", 32'(nerr), 32'd0);
`endif
    b = cap_d.size();
    send_frame(32'h1ACFFC1D, 10, 0);
    send_frame(32'hA5A55A5A, 64, 0);
    idle(4);
    chk("short_count", 32'(cap_d.size() - b), 32'd76);
    chk("short_tlast_word10", 32'(cap_l[b+10]), 32'd1);
    chk("after_short_asm", cap_d[b+11], 32'hA5A55A5A);
    chk("after_short_word1", cap_d[b+12], 32'hFF480EC0);
`ifdef RAND_FRAME_CHK_EN
    chk("short_err_pulses", 32'(nerr), 32'd1);
`endif

    for (int i = 0; i < 30; i++) send(i == 0 ? 32'h1ACFFC1D : 32'h0, 1'b0);
    m_tready = 1'b0;
    send(32'h0, 1'b0);
    idle(0);
    @(negedge core_clk);
    chk("held2_s_tready", 32'(s_tready), 32'd0);
    chk("held2_m_tvalid", 32'(m_tvalid), 32'd1);
    @(posedge core_clk);
    #1 rst = 1'b1;
    exp_q.delete();
    midx = 0;
    #1;
    chk("midrst_m_tvalid", 32'(m_tvalid), 32'd0);
    chk("midrst_s_tready", 32'(s_tready), 32'd0);
    @(posedge core_clk);
    #1 rst = 1'b0;
    m_tready = 1'b1;
    @(posedge core_clk);
    #1;
    b = cap_d.size();
    send_frame(32'h1ACFFC1D, 64, 0);
    idle(4);
    chk("postrst_count", 32'(cap_d.size() - b), 32'd65);
    chk("postrst_word0", cap_d[b], 32'h1ACFFC1D);
    chk("postrst_word1", cap_d[b+1], 32'hFF480EC0);
    chk("final_backlog", 32'(exp_q.size()), 32'd0);
`ifdef RAND_FRAME_CHK_EN
    chk("final_err_pulses", 32'(nerr), 32'd1);
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
